fetch_stage: RTL

Instruction fetch stage for the RISC-V core, directly upstream of the main decoder. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Returned instructions are buffered in a small FIFO and presented, with their PC and the 7-bit opcode field, to the decode stage under a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard in-flight responses.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem request/response tracking, instruction FIFO to decode
// Optional feature macro: FETCH_ILLEGAL_CHECK_EN (drives illegal_op from the head opcode)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  input  logic        instr_ready,
  output logic        illegal_op
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DepthW = BUF_DEPTH[CW:0];

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} stateT;

  stateT         state;
  logic [31:0]   pc;
  logic [31:0]   fifoInstr [BUF_DEPTH];
  logic [31:0]   fifoPc    [BUF_DEPTH];
  logic [31:0]   addrQ     [BUF_DEPTH];
  logic [AW-1:0] fifoRd, fifoWr, aqRd, aqWr;
  logic [CW-1:0] count, outstanding, dropCnt;

  logic          headValid, pop, reqFire, rspSeen, rspKeep, rspDrop;
  logic [CW:0]   credit;
  logic [CW-1:0] reqInc, rspDec, keepInc, popDec, dropNext;

  assign headValid = (count != '0);
  assign pop       = headValid && instr_ready;

  // Slots already committed (buffered + in flight) after this cycle's pop; a request needs a free slot
  assign credit = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};

  assign imem_req_valid = rst_n && (state == RUN) && !redirect && (credit < DepthW);
  assign imem_req_addr  = pc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored
  assign rspSeen = imem_rsp_valid && (outstanding != '0);
  assign rspDrop = rspSeen && (dropCnt != '0);
  assign rspKeep = rspSeen && (dropCnt == '0) && (state == RUN);

  assign reqInc   = {{AW{1'b0}}, reqFire};
  assign rspDec   = {{AW{1'b0}}, rspSeen};
  assign keepInc  = {{AW{1'b0}}, rspKeep};
  assign popDec   = {{AW{1'b0}}, pop};
  assign dropNext = outstanding - rspDec;

  // Control state: PC, pointers, occupancy, in-flight and discard counters, RUN/DRAIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      fifoRd      <= '0;
      fifoWr      <= '0;
      aqRd        <= '0;
      aqWr        <= '0;
    end else if (redirect && (state == RUN)) begin
      // Flush everything; whatever is still in flight after this cycle must be discarded
      pc          <= redirect_pc;
      count       <= '0;
      fifoRd      <= '0;
      fifoWr      <= '0;
      aqRd        <= '0;
      aqWr        <= '0;
      outstanding <= dropNext;
      dropCnt     <= dropNext;
      state       <= (dropNext != '0) ? DRAIN : RUN;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (reqFire) begin
        pc <= pc + 32'd4;
      end
      if (reqFire) begin
        aqWr <= aqWr + 1'b1;
      end
      if (rspKeep) begin
        fifoWr <= fifoWr + 1'b1;
        aqRd   <= aqRd + 1'b1;
      end
      if (pop) begin
        fifoRd <= fifoRd + 1'b1;
      end
      if (rspDrop) begin
        dropCnt <= dropCnt - rspDec;
      end
      outstanding <= outstanding + reqInc - rspDec;
      count       <= count + keepInc - popDec;
      if ((state == DRAIN) && (dropCnt == '0)) begin
        state <= RUN;
      end
    end
  end

  // Storage for issued addresses and returned words; validity is tracked by the counters above
  always_ff @(posedge clk) begin
    if (reqFire) begin
      addrQ[aqWr] <= pc;
    end
    if (rspKeep) begin
      fifoInstr[fifoWr] <= imem_rsp_data;
      fifoPc[fifoWr]    <= addrQ[aqRd];
    end
  end

  assign instr_valid = headValid;
  assign instr       = headValid ? fifoInstr[fifoRd] : 32'h0;
  assign instr_pc    = headValid ? fifoPc[fifoRd]    : 32'h0;
  assign op          = instr[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic opLegal;

  // Opcodes the main decoder implements; anything else is flagged but still delivered
  always_comb begin
    opLegal = 1'b0;
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b1100011, 7'b0010011, 7'b1101111: opLegal = 1'b1;
      default:                            opLegal = 1'b0;
    endcase
  end

  assign illegal_op = headValid && !opLegal;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
